// File: rtl/adder_serial_2bit.sv
// adder_serial_2bit -- digit-serial unsigned adder.
//
// Takes a full-width operand pair through a valid/ready handshake, then
// adds one 2-bit digit per clock through a single adder_2bit slice, with
// the carry chained through a register. After N = WIDTH/2 RUN cycles it
// presents {c_out, sum} = a + b + c_in through a valid/ready handshake.
// This costs latency but saves area compared with a full-width
// combinational adder.
//
// WIDTH must be even and at least 2.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; operands are taken only in IDLE
//   a, b, c_in           operands and the carry-in for the LSB digit
//   out_valid/out_ready  result handshake; the result is held in DONE
//   sum, c_out           WIDTH-bit sum and the carry out of the MSB
//   busy                 high in RUN or DONE

// One 2-bit ripple slice: {c_out, sum} = a + b + c_in.
module adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c_in,
    output logic [1:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {2'b00, c_in};
endmodule

module adder_serial_2bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, c_out_q;

    logic [1:0]       d_sum;
    logic             d_cout;
    logic [WIDTH-1:0] sum_shift;

    // The slice always sees the current low digits. Its output is only
    // used in RUN.
    adder_2bit u_slice (
        .a     (a_sh[1:0]),
        .b     (b_sh[1:0]),
        .c_in  (carry_q),
        .sum   (d_sum),
        .c_out (d_cout)
    );

    // Result digits enter at the MSB end. After N shifts the first
    // (least significant) digit has reached bits [1:0].
    generate
        if (WIDTH == 2) begin : g_one_digit
            assign sum_shift = d_sum;
        end else begin : g_multi_digit
            assign sum_shift = {d_sum, sum_q[WIDTH-1:2]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. The operand registers are the only copy of a and b, so
    // the upstream is free to change them after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    carry_q <= c_in;
                    cnt_q   <= '0;
                    sum_q   <= '0;
                end
                RUN: begin
                    a_sh    <= a_sh >> 2;
                    b_sh    <= b_sh >> 2;
                    sum_q   <= sum_shift;
                    carry_q <= d_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) c_out_q <= d_cout;
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_adder_serial_2bit.sv
module tb_adder_serial_2bit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, c_in;
    logic        in_ready, out_valid, c_out, busy;
    logic [15:0] a, b, sum;

    // Second instance for the WIDTH = 4 case
    logic        w4_in_valid, w4_out_ready, w4_c_in;
    logic        w4_in_ready, w4_out_valid, w4_c_out, w4_busy;
    logic [3:0]  w4_a, w4_b, w4_sum;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    adder_serial_2bit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    adder_serial_2bit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .c_in(w4_c_in), .out_valid(w4_out_valid),
        .out_ready(w4_out_ready), .sum(w4_sum), .c_out(w4_c_out), .busy(w4_busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    // Reference: the full-precision sum of the operands, split into carry and sum.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        return {1'b0, x} + {1'b0, y} + {16'd0, ci};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for a single edge (E0), then scramble the bus.
    task automatic accept16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    endtask

    // Count edges until out_valid is seen; -1 on timeout.
    task automatic wait16(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume16();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run16(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic [15:0] es, input logic ec,
                         input bit check_lat);
        int lat;
        accept16(x, y, ci);
        if (check_lat) check({name, " in_ready after accept"}, 32'(in_ready), 32'd0);
        wait16(lat);
        if (lat < 0) begin
            check({name, " timeout"}, 32'(lat), 32'd8);
            return;
        end
        if (check_lat) check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " sum"}, 32'(sum), 32'(es));
        check({name, " c_out"}, 32'(c_out), 32'(ec));
        consume16();
        if (check_lat) check({name, " in_ready after consume"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] m;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0; a = '0; b = '0;
        w4_in_valid = 1'b0; w4_out_ready = 1'b0; w4_c_in = 1'b0; w4_a = '0; w4_b = '0;
        tick();
        tick();

        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1});
        foreach (vecs[i])
            run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].exp_sum, vecs[i].exp_cout, 1'b1);

        // Backpressure: result must hold for 5 stalled cycles
        accept16(16'h1234, 16'h4321, 1'b1);
        wait16(lat);
        check("bp latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d sum", i), 32'(sum), 32'h5556);
            check($sformatf("bp%0d c_out", i), 32'(c_out), 32'd0);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        consume16();
        check("bp in_ready after consume", 32'(in_ready), 32'd1);
        check("bp out_valid after consume", 32'(out_valid), 32'd0);

        // in_valid pulsed during RUN must be ignored
        accept16(16'h1234, 16'h4321, 1'b1);
        tick();
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait16(lat);
        check("ignore latency", 32'(lat), 32'd6);
        check("ignore sum", 32'(sum), 32'h5556);
        check("ignore c_out", 32'(c_out), 32'd0);
        consume16();
        check("ignore back to idle", 32'(in_ready), 32'd1);
        run16("represent", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1);

        // Asynchronous reset after E3
        accept16(16'hFFFF, 16'hFFFF, 1'b1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        run16("after rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b1);

        // Random pairs with random backpressure against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
            m  = model(ra, rb, rc);
            accept16(ra, rb, rc);
            wait16(lat);
            if (lat != 8) begin
                check($sformatf("rnd%0d latency", i), 32'(lat), 32'd8);
                break;
            end
            for (int s = $urandom_range(0, 2); s > 0; s--) tick();
            check($sformatf("rnd%0d a=%h b=%h c=%0d", i, ra, rb, rc),
                  32'({c_out, sum}), 32'(m));
            consume16();
        end

        // WIDTH = 4: two RUN edges
        w4_a = 4'hF; w4_b = 4'h1; w4_c_in = 1'b0; w4_in_valid = 1'b1;
        tick();
        w4_in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (w4_out_valid) begin
                lat = i;
                break;
            end
        end
        check("w4 latency", 32'(lat), 32'd2);
        check("w4 sum", 32'(w4_sum), 32'h0);
        check("w4 c_out", 32'(w4_c_out), 32'd1);
        w4_out_ready = 1'b1;
        tick();
        w4_out_ready = 1'b0;
        check("w4 in_ready after consume", 32'(w4_in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
